ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_host_tx.sv | 168 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-side handshake between the transmitter and its user: start strobe,
// byte to send, and the idle/done/error status that comes back.
`timescale 1ns/1ps
interface ps2_host_tx_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err;

  // The user drives the request and watches the status
  modport master (
    output wr_ps2, din,
    input  tx_idle, tx_done_tick, tx_err
  );

  // The transmitter takes the request and reports status
  modport slave (
    input  wr_ps2, din,
    output tx_idle, tx_done_tick, tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send inhibit, start bit,
// eight data bits LSB first, odd parity, stop bit, then the device ack.
// Open-drain pins are modelled as pull-low enables.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave host,
  input  logic         ps2c_i,
  input  logic         ps2d_i,
  output logic         ps2c_oe_o,
  output logic         ps2d_oe_o
);

  localparam int CW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RTS, START, DATA, STOP, WAIT_END
  } state_t;

  state_t        state_q;
  logic [7:0]    filter_q, filter_d;
  logic          fclk_q, fclk_d;
  logic          fall;
  logic          dMeta_q, dSync_q;
  logic [8:0]    shreg_q;
  logic [3:0]    n_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;
  logic          ackBad_q;
  logic          cOe_q, dOe_q;
  logic          idle_q, done_q, err_q;

  // Next filter contents and filtered clock; fall marks a settled 1->0 edge
  always_comb begin
    filter_d = {ps2c_i, filter_q[7:1]};
    fclk_d   = fclk_q;
    if (&filter_d)
      fclk_d = 1'b1;
    else if (~|filter_d)
      fclk_d = 1'b0;
    fall = fclk_q & ~fclk_d;
  end

  // Clock deglitch filter and two-flop synchronizer for the data pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter_q <= '0;
      fclk_q   <= 1'b0;
      dMeta_q  <= 1'b0;
      dSync_q  <= 1'b0;
    end else begin
      filter_q <= filter_d;
      fclk_q   <= fclk_d;
      dMeta_q  <= ps2d_i;
      dSync_q  <= dMeta_q;
    end
  end

  // Transfer sequencer; pin enables and status are registered so nothing
  // from the pins can reach the open-drain drivers combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      ackBad_q <= 1'b0;
      cOe_q    <= 1'b0;
      dOe_q    <= 1'b0;
      idle_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host.wr_ps2) begin
            shreg_q <= {~^host.din, host.din};
            err_q   <= 1'b0;
            cnt_q   <= '0;
            cOe_q   <= 1'b1;
            dOe_q   <= 1'b1;
            idle_q  <= 1'b0;
            state_q <= RTS;
          end
        end
        RTS: begin
          if (cnt_q == INH_LAST) begin
            cOe_q   <= 1'b0;
            dOe_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= START;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (tmo_q == TMO_LAST) begin
            cOe_q   <= 1'b0;
            dOe_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            idle_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            case (state_q)
              START: begin
                if (fall) begin
                  n_q     <= 4'd8;
                  dOe_q   <= ~shreg_q[0];
                  state_q <= DATA;
                end
              end
              DATA: begin
                if (fall) begin
                  if (n_q != 4'd0) begin
                    shreg_q <= {1'b0, shreg_q[8:1]};
                    n_q     <= n_q - 4'd1;
                    dOe_q   <= ~shreg_q[1];
                  end else begin
                    dOe_q   <= 1'b0;
                    state_q <= STOP;
                  end
                end
              end
              STOP: begin
                if (fall) begin
                  ackBad_q <= dSync_q;
                  state_q  <= WAIT_END;
                end
              end
              WAIT_END: begin
                if (fclk_q && dSync_q) begin
                  done_q  <= 1'b1;
                  err_q   <= ackBad_q;
                  idle_q  <= 1'b1;
                  state_q <= IDLE;
                end
              end
              default: begin
                cOe_q   <= 1'b0;
                dOe_q   <= 1'b0;
                idle_q  <= 1'b1;
                state_q <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign ps2c_oe_o         = cOe_q;
  assign ps2d_oe_o         = dOe_q;
  assign host.tx_idle      = idle_q;
  assign host.tx_done_tick = done_q;
  assign host.tx_err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a small PS/2 device model clocks frames out of the
// host over wired-AND pins; expected line bits and error flags are queued
// when each write is issued and compared as the device samples them.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 500;
  localparam int TMO = 3000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic devC  = 1'b1;
  logic devD  = 1'b1;
  logic ps2cOe, ps2dOe;
  logic ps2cLine, ps2dLine;

  int   total = 0;
  int   bad   = 0;
  int   doneCount = 0;
  logic bitQ[$];
  logic errQ[$];
  logic sampled[11];

  assign ps2cLine = devC & ~ps2cOe;
  assign ps2dLine = devD & ~ps2dOe;

  ps2_host_tx_if ifc();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (ifc),
    .ps2c_i    (ps2cLine),
    .ps2d_i    (ps2dLine),
    .ps2c_oe_o (ps2cOe),
    .ps2d_oe_o (ps2dOe)
  );

  // 100 MHz-style bench clock; only relative cycle counts matter
  always #5 clk = ~clk;

  // Count every done tick so reset-time ticks can be detected
  always @(negedge clk) begin
    if (ifc.tx_done_tick === 1'b1) doneCount = doneCount + 1;
  end

  // Issue one write strobe and queue what the device should see
  task automatic applyStimulus(input logic [7:0] b, input logic expErr, input bit withFrame);
    int ones;
    @(negedge clk);
    ifc.wr_ps2 = 1'b1;
    ifc.din    = b;
    if (withFrame) begin
      ones = 0;
      bitQ.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
        bitQ.push_back(b[i]);
        if (b[i]) ones++;
      end
      bitQ.push_back((ones % 2) == 0);
      bitQ.push_back(1'b1);
    end
    errQ.push_back(expErr);
    @(negedge clk);
    ifc.wr_ps2 = 1'b0;
    ifc.din    = 8'($urandom);
  endtask

  // Device side: wait out RTS, then clock nFalls bits, sampling the data
  // line just before each falling edge
  task automatic runFrame(input int nFalls, input bit ack, input bit inject, input bit glitch,
                          input bit waitDone, output int rtsLen, output bit doneSeen,
                          output bit errSeen, output bit idleAfter);
    int w;
    rtsLen = 0;
    while (ps2cOe === 1'b1 && rtsLen < INH + 20) begin
      rtsLen++;
      @(negedge clk);
    end
    repeat (16) @(negedge clk);
    for (int k = 0; k < nFalls; k++) begin
      sampled[k] = ps2dLine;
      if (k == 10 && ack) devD = 1'b0;
      devC = 1'b0;
      if (inject && k == 4) begin
        repeat (5) @(negedge clk);
        ifc.wr_ps2 = 1'b1;
        ifc.din    = 8'h55;
        @(negedge clk);
        ifc.wr_ps2 = 1'b0;
        repeat (14) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      devC = 1'b1;
      devD = 1'b1;
      if (k != nFalls - 1) begin
        if (glitch && k == 6) begin
          repeat (6) @(negedge clk);
          devC = 1'b0;
          repeat (3) @(negedge clk);
          devC = 1'b1;
          repeat (11) @(negedge clk);
        end else begin
          repeat (20) @(negedge clk);
        end
      end
    end
    doneSeen = 1'b0; errSeen = 1'b0; idleAfter = 1'b0;
    if (waitDone) begin
      w = 0;
      while (ifc.tx_done_tick !== 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      doneSeen  = ifc.tx_done_tick;
      errSeen   = ifc.tx_err;
      idleAfter = ifc.tx_idle;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (ps2cOe !== 1'b0) begin bad++; $display("[TB] FAIL rst_c_oe got=%b want=0", ps2cOe); end
    total++; if (ps2dOe !== 1'b0) begin bad++; $display("[TB] FAIL rst_d_oe got=%b want=0", ps2dOe); end
    total++; if (ifc.tx_idle !== 1'b1) begin bad++; $display("[TB] FAIL rst_idle got=%b want=1", ifc.tx_idle); end
    total++; if (ifc.tx_done_tick !== 1'b0) begin bad++; $display("[TB] FAIL rst_done got=%b want=0", ifc.tx_done_tick); end
    total++; if (ifc.tx_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_err got=%b want=0", ifc.tx_err); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic();
    int rts; bit dn, er, idl; logic e;
    applyStimulus(8'hED, 1'b0, 1'b1);
    total++; if (ifc.tx_idle !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy got=%b want=0", ifc.tx_idle); end
    runFrame(11, 1'b1, 1'b0, 1'b0, 1'b1, rts, dn, er, idl);
    total++; if (rts != INH) begin bad++; $display("[TB] FAIL basic_rts_len got=%0d want=%0d", rts, INH); end
    for (int i = 0; i < 11; i++) begin
      e = (bitQ.size() > 0) ? bitQ.pop_front() : 1'bx;
      total++; if (sampled[i] !== e) begin bad++; $display("[TB] FAIL basic_bit%0d got=%b want=%b", i, sampled[i], e); end
    end
    e = errQ.pop_front();
    total++; if (dn !== 1'b1) begin bad++; $display("[TB] FAIL basic_done got=%b want=1", dn); end
    total++; if (er !== e) begin bad++; $display("[TB] FAIL basic_err got=%b want=%b", er, e); end
    total++; if (idl !== 1'b1) begin bad++; $display("[TB] FAIL basic_idle got=%b want=1", idl); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_parity();
    logic [7:0] bytes [3];
    logic       parExp [3];
    int rts; bit dn, er, idl; logic e;
    bytes[0] = 8'h00; parExp[0] = 1'b1;
    bytes[1] = 8'h01; parExp[1] = 1'b0;
    bytes[2] = 8'hFF; parExp[2] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      applyStimulus(bytes[t], 1'b0, 1'b1);
      runFrame(11, 1'b1, 1'b0, 1'b0, 1'b1, rts, dn, er, idl);
      total++; if (sampled[9] !== parExp[t]) begin bad++; $display("[TB] FAIL parity_%h got=%b want=%b", bytes[t], sampled[9], parExp[t]); end
      for (int i = 0; i < 11; i++) begin
        e = (bitQ.size() > 0) ? bitQ.pop_front() : 1'bx;
        total++; if (sampled[i] !== e) begin bad++; $display("[TB] FAIL parity_%h_bit%0d got=%b want=%b", bytes[t], i, sampled[i], e); end
      end
      e = errQ.pop_front();
      total++; if (dn !== 1'b1 || er !== e) begin bad++; $display("[TB] FAIL parity_%h_done got=%b/%b want=1/%b", bytes[t], dn, er, e); end
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_no_ack();
    int rts; bit dn, er, idl; logic e;
    applyStimulus(8'h5A, 1'b1, 1'b1);
    runFrame(11, 1'b0, 1'b0, 1'b0, 1'b1, rts, dn, er, idl);
    for (int i = 0; i < 11; i++) begin
      e = (bitQ.size() > 0) ? bitQ.pop_front() : 1'bx;
      total++; if (sampled[i] !== e) begin bad++; $display("[TB] FAIL noack_bit%0d got=%b want=%b", i, sampled[i], e); end
    end
    e = errQ.pop_front();
    total++; if (dn !== 1'b1) begin bad++; $display("[TB] FAIL noack_done got=%b want=1", dn); end
    total++; if (er !== e) begin bad++; $display("[TB] FAIL noack_err got=%b want=%b", er, e); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_timeout();
    int rts; int k; logic e;
    total++; if (ifc.tx_err !== 1'b1) begin bad++; $display("[TB] FAIL err_held got=%b want=1", ifc.tx_err); end
    applyStimulus(8'h3C, 1'b1, 1'b0);
    total++; if (ifc.tx_err !== 1'b0) begin bad++; $display("[TB] FAIL err_clear got=%b want=0", ifc.tx_err); end
    rts = 0;
    while (ps2cOe === 1'b1 && rts < INH + 20) begin
      rts++;
      @(negedge clk);
    end
    k = 0;
    while (ps2dOe === 1'b1 && k < TMO + 50) begin
      @(negedge clk);
      k++;
    end
    e = errQ.pop_front();
    total++; if (k != TMO) begin bad++; $display("[TB] FAIL tmo_cycles got=%0d want=%0d", k, TMO); end
    total++; if (ps2cOe !== 1'b0) begin bad++; $display("[TB] FAIL tmo_c_oe got=%b want=0", ps2cOe); end
    total++; if (ifc.tx_done_tick !== 1'b1) begin bad++; $display("[TB] FAIL tmo_done got=%b want=1", ifc.tx_done_tick); end
    total++; if (ifc.tx_err !== e) begin bad++; $display("[TB] FAIL tmo_err got=%b want=%b", ifc.tx_err, e); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_mid_events();
    int rts; bit dn, er, idl; logic e;
    applyStimulus(8'hA3, 1'b0, 1'b1);
    runFrame(11, 1'b1, 1'b1, 1'b1, 1'b1, rts, dn, er, idl);
    for (int i = 0; i < 11; i++) begin
      e = (bitQ.size() > 0) ? bitQ.pop_front() : 1'bx;
      total++; if (sampled[i] !== e) begin bad++; $display("[TB] FAIL mid_bit%0d got=%b want=%b", i, sampled[i], e); end
    end
    e = errQ.pop_front();
    total++; if (dn !== 1'b1 || er !== e) begin bad++; $display("[TB] FAIL mid_done got=%b/%b want=1/%b", dn, er, e); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rts; int dc; bit dn, er, idl; logic e;
    applyStimulus(8'h9A, 1'b0, 1'b1);
    runFrame(5, 1'b0, 1'b0, 1'b0, 1'b0, rts, dn, er, idl);
    for (int i = 0; i < 5; i++) begin
      e = (bitQ.size() > 0) ? bitQ.pop_front() : 1'bx;
      total++; if (sampled[i] !== e) begin bad++; $display("[TB] FAIL rstmid_bit%0d got=%b want=%b", i, sampled[i], e); end
    end
    bitQ.delete();
    errQ.delete();
    #1;
    dc = doneCount;
    reset = 1'b1;
    #1;
    total++; if (ps2cOe !== 1'b0 || ps2dOe !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_oe got=%b%b want=00", ps2cOe, ps2dOe); end
    total++; if (ifc.tx_idle !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_idle got=%b want=1", ifc.tx_idle); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    total++; if (doneCount != dc) begin bad++; $display("[TB] FAIL rstmid_no_tick got=%0d want=%0d", doneCount, dc); end
    applyStimulus(8'hF4, 1'b0, 1'b1);
    runFrame(11, 1'b1, 1'b0, 1'b0, 1'b1, rts, dn, er, idl);
    for (int i = 0; i < 11; i++) begin
      e = (bitQ.size() > 0) ? bitQ.pop_front() : 1'bx;
      total++; if (sampled[i] !== e) begin bad++; $display("[TB] FAIL f4_bit%0d got=%b want=%b", i, sampled[i], e); end
    end
    e = errQ.pop_front();
    total++; if (dn !== 1'b1) begin bad++; $display("[TB] FAIL f4_done got=%b want=1", dn); end
    total++; if (er !== e) begin bad++; $display("[TB] FAIL f4_err got=%b want=%b", er, e); end
    repeat (10) @(negedge clk);
  endtask

  // Run every scenario in order, then report
  initial begin
    ifc.wr_ps2 = 1'b0;
    ifc.din    = 8'h00;
    test_reset();
    test_basic();
    test_parity();
    test_no_ack();
    test_timeout();
    test_mid_events();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
